// File: rtl/friscv_dmem_bridge.sv
// Data-memory bridge between the memfy stage and a word-organised fixed-latency SRAM.
// Optional misaligned-store trap: define FRISCV_DMEM_MISALIGN_EXC_EN to add mem_misalign.
module friscv_dmem_bridge #(
    parameter int unsigned ADDRW      = 16,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned RD_LATENCY = 1
)(
    input  logic                aclk,
    input  logic                areset,
    input  logic                srst,
    input  logic                mem_en,
    input  logic                mem_wr,
    input  logic [ADDRW-1:0]    mem_addr,
    input  logic [XLEN-1:0]     mem_wdata,
    input  logic [XLEN/8-1:0]   mem_strb,
    output logic [XLEN-1:0]     mem_rdata,
    output logic                mem_ready,
    output logic                ram_en,
    output logic                ram_wr,
    output logic [ADDRW-3:0]    ram_addr,
    output logic [XLEN-1:0]     ram_wdata,
    output logic [XLEN/8-1:0]   ram_wstrb,
    input  logic [XLEN-1:0]     ram_rdata
`ifdef FRISCV_DMEM_MISALIGN_EXC_EN
    ,
    output logic                mem_misalign
`endif
);

    localparam int unsigned STRBW = XLEN / 8;
    localparam int unsigned CNTW  = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        READ_WAIT = 3'd2,
        RESP      = 3'd3,
        HOLD      = 3'd4
    } state_t;

    state_t            state;
    logic [CNTW-1:0]   cnt;
    logic [1:0]        off_q;

    logic [1:0]        off_c;
    logic [XLEN-1:0]   wdata_al_c;
    logic [STRBW-1:0]  wstrb_al_c;

    // Lane alignment of the incoming request; out-of-word lanes fall off the top.
    assign off_c      = mem_addr[1:0];
    assign wdata_al_c = mem_wdata << {off_c, 3'b000};
    assign wstrb_al_c = mem_strb << off_c;

`ifdef FRISCV_DMEM_MISALIGN_EXC_EN
    logic [2*STRBW-1:0] strb_wide_c;
    logic               misalign_c;

    assign strb_wide_c = {{STRBW{1'b0}}, mem_strb} << off_c;
    assign misalign_c  = mem_wr && (strb_wide_c[2*STRBW-1:STRBW] != '0);
`endif

    // Request FSM; every output is a register updated here.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            cnt       <= '0;
            off_q     <= '0;
            mem_rdata <= '0;
            mem_ready <= 1'b0;
            ram_en    <= 1'b0;
            ram_wr    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wstrb <= '0;
`ifdef FRISCV_DMEM_MISALIGN_EXC_EN
            mem_misalign <= 1'b0;
`endif
        end else if (srst) begin
            state     <= IDLE;
            cnt       <= '0;
            off_q     <= '0;
            mem_rdata <= '0;
            mem_ready <= 1'b0;
            ram_en    <= 1'b0;
            ram_wr    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wstrb <= '0;
`ifdef FRISCV_DMEM_MISALIGN_EXC_EN
            mem_misalign <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (mem_en) begin
                        off_q <= off_c;
`ifdef FRISCV_DMEM_MISALIGN_EXC_EN
                        if (misalign_c) begin
                            mem_ready    <= 1'b1;
                            mem_misalign <= 1'b1;
                            state        <= RESP;
                        end else
`endif
                        begin
                            ram_en    <= 1'b1;
                            ram_wr    <= mem_wr;
                            ram_addr  <= mem_addr[ADDRW-1:2];
                            ram_wdata <= wdata_al_c;
                            ram_wstrb <= wstrb_al_c;
                            if (mem_wr) begin
                                state <= WRITE;
                            end else begin
                                cnt   <= CNTW'(RD_LATENCY);
                                state <= READ_WAIT;
                            end
                        end
                    end
                end
                WRITE: begin
                    ram_en    <= 1'b0;
                    mem_ready <= 1'b1;
                    state     <= RESP;
                end
                READ_WAIT: begin
                    ram_en <= 1'b0;
                    // Counter reaches zero in the cycle the SRAM data is valid.
                    if (cnt == '0) begin
                        mem_rdata <= ram_rdata >> {off_q, 3'b000};
                        mem_ready <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    mem_ready <= 1'b0;
`ifdef FRISCV_DMEM_MISALIGN_EXC_EN
                    mem_misalign <= 1'b0;
`endif
                    state <= HOLD;
                end
                HOLD: begin
                    // Dead cycle swallowing memfy's late release of mem_en.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_friscv_dmem_bridge.sv
// Self-checking bench for friscv_dmem_bridge: directed steps plus random loads/stores
// against a word-array reference model, with a fixed-latency SRAM model on the RAM side.
module tb_friscv_dmem_bridge;

    localparam int unsigned ADDRW  = 16;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned RD_LAT = 3;
    localparam int unsigned NWORDS = 1 << (ADDRW - 2);

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        srst = 1'b0;
    logic        mem_en = 1'b0;
    logic        mem_wr = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_strb = '0;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        ram_en;
    logic        ram_wr;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wstrb;
    logic [31:0] ram_rdata;
`ifdef FRISCV_DMEM_MISALIGN_EXC_EN
    logic        mem_misalign;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] sram    [NWORDS];
    logic [31:0] ref_mem [NWORDS];
    logic [31:0] rd_pipe [RD_LAT];
    logic [31:0] last_rdata;

    bit          r_wr;
    bit          r_drop;
    logic [15:0] r_addr;
    logic [31:0] r_wd;
    logic [3:0]  r_st;

    friscv_dmem_bridge #(
        .ADDRW      (ADDRW),
        .XLEN       (XLEN),
        .RD_LATENCY (RD_LAT)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .srst      (srst),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_strb  (mem_strb),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .ram_en    (ram_en),
        .ram_wr    (ram_wr),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wstrb (ram_wstrb),
        .ram_rdata (ram_rdata)
`ifdef FRISCV_DMEM_MISALIGN_EXC_EN
        ,
        .mem_misalign (mem_misalign)
`endif
    );

    always #5 aclk = ~aclk;

    // SRAM: data valid RD_LAT cycles after the ram_en cycle, junk otherwise.
    assign ram_rdata = rd_pipe[RD_LAT-1];
    always @(posedge aclk) begin
        for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= (ram_en && !ram_wr) ? sram[ram_addr] : $urandom;
        if (ram_en && ram_wr)
            for (int b = 0; b < 4; b++)
                if (ram_wstrb[b]) sram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".mem_ready"}, 32'(mem_ready), 32'h0);
        check({tag, ".mem_rdata"}, mem_rdata, 32'h0);
        check({tag, ".ram_en"},    32'(ram_en), 32'h0);
        check({tag, ".ram_wr"},    32'(ram_wr), 32'h0);
        check({tag, ".ram_addr"},  32'(ram_addr), 32'h0);
        check({tag, ".ram_wdata"}, ram_wdata, 32'h0);
        check({tag, ".ram_wstrb"}, 32'(ram_wstrb), 32'h0);
`ifdef FRISCV_DMEM_MISALIGN_EXC_EN
        check({tag, ".mem_misalign"}, 32'(mem_misalign), 32'h0);
`endif
    endtask

    // One memfy transaction: mem_en held until one cycle after mem_ready is seen.
    task automatic do_req(input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                          input logic [3:0] st, input bit drop);
        logic [1:0]  off;
        logic [7:0]  wide;
        bit          mis;
        int          idx;
        int          exp_rdy, n_en, en_k, n_rdy, rdy_k;
        logic [31:0] exp_wd, exp_rd;
        logic [3:0]  exp_st;
        off    = addr[1:0];
        idx    = int'(addr[15:2]);
        wide   = 8'(st) << off;
        mis    = 1'b0;
`ifdef FRISCV_DMEM_MISALIGN_EXC_EN
        mis    = wr && (wide[7:4] != 4'h0);
`endif
        exp_st  = wide[3:0];
        exp_wd  = wd << (8 * off);
        exp_rd  = wr ? last_rdata : (ref_mem[idx] >> (8 * off));
        exp_rdy = mis ? 1 : (wr ? 2 : 2 + int'(RD_LAT));
        n_en = 0; en_k = 0; n_rdy = 0; rdy_k = 0;
        mem_en    = 1'b1;
        mem_wr    = wr;
        mem_addr  = addr;
        mem_wdata = wd;
        mem_strb  = wr ? st : 4'h0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (drop && k == 1) mem_en = 1'b0;
            if (ram_en === 1'b1) begin
                n_en++;
                en_k = k;
                check("ram_wr", 32'(ram_wr), 32'(wr));
                check("ram_addr", 32'(ram_addr), 32'(addr[15:2]));
                if (wr) begin
                    check("ram_wdata", ram_wdata, exp_wd);
                    check("ram_wstrb", 32'(ram_wstrb), 32'(exp_st));
                end
            end
            if (mem_ready === 1'b1) begin
                n_rdy++;
                rdy_k = k;
                check("mem_rdata", mem_rdata, exp_rd);
`ifdef FRISCV_DMEM_MISALIGN_EXC_EN
                check("mem_misalign", 32'(mem_misalign), 32'(mis));
`endif
            end
            if (rdy_k > 0 && k == rdy_k + 2) mem_en = 1'b0;
            if (rdy_k > 0 && k >= rdy_k + 3) break;
        end
        mem_en = 1'b0;
        check("ram_en_pulses", 32'(n_en), mis ? 32'h0 : 32'h1);
        if (!mis) check("ram_en_cycle", 32'(en_k), 32'h1);
        check("ready_pulses", 32'(n_rdy), 32'h1);
        check("ready_cycle", 32'(exp_rdy == rdy_k ? rdy_k : rdy_k), 32'(exp_rdy));
        if (wr && !mis)
            for (int b = 0; b < 4; b++)
                if (exp_st[b]) ref_mem[idx][8*b +: 8] = exp_wd[8*b +: 8];
        if (!wr) last_rdata = exp_rd;
    endtask

    initial begin
        for (int i = 0; i < int'(NWORDS); i++) begin
            sram[i]    = '0;
            ref_mem[i] = '0;
        end
        for (int i = 0; i < int'(RD_LAT); i++) rd_pipe[i] = '0;
        last_rdata = '0;

        // Reset state
        areset = 1'b1;
        repeat (3) tick();
        check_zero("reset");
        areset = 1'b0;
        tick();

        // Directed stores, loads and alignment cases
        do_req(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b0);
        do_req(1'b1, 16'h0013, 32'h000000AB, 4'h1, 1'b0);
        do_req(1'b1, 16'h0020, 32'h1234ABCD, 4'hF, 1'b0);
        do_req(1'b0, 16'h0022, 32'h0, 4'h0, 1'b0);
        check("load_hw_value", last_rdata, 32'h00001234);
        do_req(1'b1, 16'h0003, 32'h0000CDAB, 4'h3, 1'b0);
        do_req(1'b0, 16'h0000, 32'h0, 4'h0, 1'b0);
        do_req(1'b0, 16'h0010, 32'h0, 4'h0, 1'b1);
        do_req(1'b1, 16'h0005, 32'h00005A5A, 4'h3, 1'b1);
        do_req(1'b0, 16'h0007, 32'h0, 4'h0, 1'b0);

        // Asynchronous reset in the middle of a load
        mem_wr = 1'b0; mem_addr = 16'h0022; mem_strb = 4'h0; mem_en = 1'b1;
        tick();
        check("areset_pre.ram_en", 32'(ram_en), 32'h1);
        tick();
        areset = 1'b1;
        mem_en = 1'b0;
        #1;
        check_zero("areset_mid");
        tick();
        areset = 1'b0;
        last_rdata = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("areset_no_ready", 32'(mem_ready), 32'h0);
        end
        do_req(1'b0, 16'h0020, 32'h0, 4'h0, 1'b0);

        // Synchronous reset in the ram_en cycle of a store
        mem_wr = 1'b1; mem_addr = 16'h0040; mem_wdata = 32'h55AA55AA; mem_strb = 4'hF; mem_en = 1'b1;
        tick();
        check("srst_pre.ram_en", 32'(ram_en), 32'h1);
        srst = 1'b1;
        mem_en = 1'b0;
        tick();
        check_zero("srst_mid");
        srst = 1'b0;
        ref_mem[16] = 32'h55AA55AA;
        last_rdata = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("srst_no_ready", 32'(mem_ready), 32'h0);
        end

        // Random traffic over a small window so words get reused
        for (int t = 0; t < 40; t++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_addr = 16'($urandom_range(0, 71));
            r_wd   = $urandom;
            r_st   = 4'($urandom_range(1, 15));
            r_drop = ($urandom_range(0, 4) == 0);
            do_req(r_wr, r_addr, r_wd, r_st, r_drop);
        end

        // Read back every word of the window
        for (int w = 0; w < 18; w++) begin
            do_req(1'b0, 16'(w * 4), $urandom, 4'h0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
